// File: rtl/pkt_recv_module.sv
`default_nettype none
// ============================================================================
// Module   : pkt_recv_module
// Purpose  : Per-port packet receiver/checker. Parses the header beat of each
//            packet on the rd_* stream, accumulates payload beat count and a
//            16-bit checksum, then reports completion, decoded header fields,
//            error flags and running good/bad packet counts.
// Ports    : clk, rst          - clock, asynchronous active-high reset
//            rx_en             - permits acceptance of new packets
//            rd_sop/eop/vld    - beat framing and valid
//            rd_data           - beat data (header or payload)
//            ready             - beat acceptance
//            pkt_done          - one-cycle completion pulse
//            pkt_err           - {framing, checksum, length, destination}
//            pkt_dest/priority - header fields of the last reported packet
//            pkt_length        - payload beats received (saturating)
//            pkt_cnt/err_cnt   - wrapping good/bad packet counters
// Revision : 1.0 - initial release
// ============================================================================
module pkt_recv_module #(
    parameter int DATA_WIDTH     = 32,
    parameter int PORT_ID        = 0,
    parameter int WIDTH_SEL      = 3,
    parameter int WIDTH_PRIORITY = 3,
    parameter int WIDTH_LENGTH   = 9
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rx_en,
    input  logic                      rd_sop,
    input  logic                      rd_eop,
    input  logic                      rd_vld,
    input  logic [DATA_WIDTH-1:0]     rd_data,
    output logic                      ready,
    output logic                      pkt_done,
    output logic [3:0]                pkt_err,
    output logic [WIDTH_SEL-1:0]      pkt_dest,
    output logic [WIDTH_PRIORITY-1:0] pkt_priority,
    output logic [WIDTH_LENGTH-1:0]   pkt_length,
    output logic [15:0]               pkt_cnt,
    output logic [15:0]               err_cnt
);

    // Header bit offsets, LSB first: dest, priority, length, checksum.
    localparam int c_off_pri  = WIDTH_SEL;
    localparam int c_off_len  = WIDTH_SEL + WIDTH_PRIORITY;
    localparam int c_off_csum = WIDTH_SEL + WIDTH_PRIORITY + WIDTH_LENGTH;
    localparam logic [WIDTH_SEL-1:0] c_port = WIDTH_SEL'(PORT_ID);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RECV  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                    state_q, state_d;
    logic [WIDTH_SEL-1:0]      hdr_dest_q, hdr_dest_d;
    logic [WIDTH_PRIORITY-1:0] hdr_pri_q,  hdr_pri_d;
    logic [WIDTH_LENGTH-1:0]   hdr_len_q,  hdr_len_d;
    logic [15:0]               hdr_csum_q, hdr_csum_d;
    logic [WIDTH_LENGTH-1:0]   cnt_q,      cnt_d;
    logic [15:0]               acc_q,      acc_d;
    // nohdr: current frame started without a header (stray beats); only the
    // framing flag is meaningful for such a frame.
    logic                      nohdr_q,    nohdr_d;
    // pend: a header-only packet arrived as a mid-packet sop together with
    // eop; its report is issued from DONE, after the aborted packet's report.
    logic                      pend_q,     pend_d;

    logic                      pkt_done_q;
    logic [3:0]                pkt_err_q;
    logic [WIDTH_SEL-1:0]      pkt_dest_q;
    logic [WIDTH_PRIORITY-1:0] pkt_priority_q;
    logic [WIDTH_LENGTH-1:0]   pkt_length_q;
    logic [15:0]               pkt_cnt_q;
    logic [15:0]               err_cnt_q;

    // Report request and the values it is checked against.
    logic                      rep_vld;
    logic [WIDTH_SEL-1:0]      rep_dest;
    logic [WIDTH_PRIORITY-1:0] rep_pri;
    logic [WIDTH_LENGTH-1:0]   rep_len;
    logic [15:0]               rep_csum;
    logic [WIDTH_LENGTH-1:0]   rep_cnt;
    logic [15:0]               rep_acc;
    logic                      rep_frame;
    logic                      rep_nohdr;
    logic [3:0]                rep_err;

    logic                      w_ready;
    logic                      w_accept;
    logic [WIDTH_SEL-1:0]      w_beat_dest;
    logic [WIDTH_PRIORITY-1:0] w_beat_pri;
    logic [WIDTH_LENGTH-1:0]   w_beat_len;
    logic [15:0]               w_beat_csum;
    logic [WIDTH_LENGTH-1:0]   w_cnt_inc;
    logic                      w_unused;

    assign w_beat_dest = rd_data[c_off_pri-1:0];
    assign w_beat_pri  = rd_data[c_off_len-1:c_off_pri];
    assign w_beat_len  = rd_data[c_off_csum-1:c_off_len];
    assign w_beat_csum = rd_data[c_off_csum+15:c_off_csum];
    assign w_unused    = &{1'b0, rd_data};

    // Saturating payload beat counter.
    assign w_cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        w_ready = 1'b0;
        case (state_q)
            S_IDLE:  w_ready = rx_en;
            S_RECV,
            S_DRAIN: w_ready = 1'b1;
            default: w_ready = 1'b0;
        endcase
    end

    // ready is forced low while reset is asserted, not just after it.
    assign ready    = w_ready & ~rst;
    assign w_accept = rd_vld & w_ready;

    always_comb begin
        state_d    = state_q;
        hdr_dest_d = hdr_dest_q;
        hdr_pri_d  = hdr_pri_q;
        hdr_len_d  = hdr_len_q;
        hdr_csum_d = hdr_csum_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        nohdr_d    = nohdr_q;
        pend_d     = pend_q;
        rep_vld    = 1'b0;
        rep_dest   = hdr_dest_q;
        rep_pri    = hdr_pri_q;
        rep_len    = hdr_len_q;
        rep_csum   = hdr_csum_q;
        rep_cnt    = cnt_q;
        rep_acc    = acc_q;
        rep_frame  = 1'b0;
        rep_nohdr  = nohdr_q;

        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    cnt_d = '0;
                    acc_d = '0;
                    if (rd_sop) begin
                        hdr_dest_d = w_beat_dest;
                        hdr_pri_d  = w_beat_pri;
                        hdr_len_d  = w_beat_len;
                        hdr_csum_d = w_beat_csum;
                        nohdr_d    = 1'b0;
                        if (rd_eop) begin
                            rep_vld   = 1'b1;
                            rep_dest  = w_beat_dest;
                            rep_pri   = w_beat_pri;
                            rep_len   = w_beat_len;
                            rep_csum  = w_beat_csum;
                            rep_cnt   = '0;
                            rep_acc   = '0;
                            rep_nohdr = 1'b0;
                            state_d   = S_DONE;
                        end else begin
                            state_d = S_RECV;
                        end
                    end else begin
                        // Stray beat: no header to check against.
                        hdr_dest_d = '0;
                        hdr_pri_d  = '0;
                        hdr_len_d  = '0;
                        hdr_csum_d = '0;
                        nohdr_d    = 1'b1;
                        if (rd_eop) begin
                            rep_vld   = 1'b1;
                            rep_dest  = '0;
                            rep_pri   = '0;
                            rep_len   = '0;
                            rep_csum  = '0;
                            rep_cnt   = '0;
                            rep_acc   = '0;
                            rep_frame = 1'b1;
                            rep_nohdr = 1'b1;
                            state_d   = S_DONE;
                        end else begin
                            state_d = S_DRAIN;
                        end
                    end
                end
            end

            S_RECV, S_DRAIN: begin
                if (w_accept) begin
                    if (rd_sop) begin
                        // Unexpected sop: close the open frame as a framing
                        // error and start the new packet in the same cycle.
                        rep_vld    = 1'b1;
                        rep_frame  = 1'b1;
                        hdr_dest_d = w_beat_dest;
                        hdr_pri_d  = w_beat_pri;
                        hdr_len_d  = w_beat_len;
                        hdr_csum_d = w_beat_csum;
                        cnt_d      = '0;
                        acc_d      = '0;
                        nohdr_d    = 1'b0;
                        if (rd_eop) begin
                            pend_d  = 1'b1;
                            state_d = S_DONE;
                        end else begin
                            state_d = S_RECV;
                        end
                    end else if (state_q == S_RECV) begin
                        cnt_d = w_cnt_inc;
                        acc_d = acc_q + rd_data[15:0];
                        if (rd_eop) begin
                            rep_vld = 1'b1;
                            rep_cnt = w_cnt_inc;
                            rep_acc = acc_q + rd_data[15:0];
                            state_d = S_DONE;
                        end
                    end else if (rd_eop) begin
                        rep_vld   = 1'b1;
                        rep_frame = 1'b1;
                        state_d   = S_DONE;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
                if (pend_q) begin
                    rep_vld = 1'b1;
                    pend_d  = 1'b0;
                end
            end
        endcase
    end

    always_comb begin
        rep_err = {rep_frame, 3'b000};
        if (!rep_nohdr) begin
            rep_err[0] = (rep_dest != c_port);
            rep_err[1] = (rep_cnt != rep_len);
            rep_err[2] = (rep_acc != rep_csum);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            hdr_dest_q     <= '0;
            hdr_pri_q      <= '0;
            hdr_len_q      <= '0;
            hdr_csum_q     <= '0;
            cnt_q          <= '0;
            acc_q          <= '0;
            nohdr_q        <= 1'b0;
            pend_q         <= 1'b0;
            pkt_done_q     <= 1'b0;
            pkt_err_q      <= '0;
            pkt_dest_q     <= '0;
            pkt_priority_q <= '0;
            pkt_length_q   <= '0;
            pkt_cnt_q      <= '0;
            err_cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            hdr_dest_q <= hdr_dest_d;
            hdr_pri_q  <= hdr_pri_d;
            hdr_len_q  <= hdr_len_d;
            hdr_csum_q <= hdr_csum_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            nohdr_q    <= nohdr_d;
            pend_q     <= pend_d;
            pkt_done_q <= rep_vld;
            if (rep_vld) begin
                pkt_err_q      <= rep_err;
                pkt_dest_q     <= rep_dest;
                pkt_priority_q <= rep_pri;
                pkt_length_q   <= rep_cnt;
                if (rep_err == 4'b0000) begin
                    pkt_cnt_q <= pkt_cnt_q + 16'd1;
                end else begin
                    err_cnt_q <= err_cnt_q + 16'd1;
                end
            end
        end
    end

    assign pkt_done     = pkt_done_q;
    assign pkt_err      = pkt_err_q;
    assign pkt_dest     = pkt_dest_q;
    assign pkt_priority = pkt_priority_q;
    assign pkt_length   = pkt_length_q;
    assign pkt_cnt      = pkt_cnt_q;
    assign err_cnt      = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pkt_recv_module.sv
`default_nettype none
// ============================================================================
// Module   : tb_pkt_recv_module
// Purpose  : Directed self-checking bench for pkt_recv_module (PORT_ID=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pkt_recv_module;

    logic        clk;
    logic        rst;
    logic        rx_en;
    logic        rd_sop;
    logic        rd_eop;
    logic        rd_vld;
    logic [31:0] rd_data;
    logic        ready;
    logic        pkt_done;
    logic [3:0]  pkt_err;
    logic [2:0]  pkt_dest;
    logic [2:0]  pkt_priority;
    logic [8:0]  pkt_length;
    logic [15:0] pkt_cnt;
    logic [15:0] err_cnt;

    int total = 0;
    int bad   = 0;

    pkt_recv_module #(
        .DATA_WIDTH     (32),
        .PORT_ID        (2),
        .WIDTH_SEL      (3),
        .WIDTH_PRIORITY (3),
        .WIDTH_LENGTH   (9)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_en        (rx_en),
        .rd_sop       (rd_sop),
        .rd_eop       (rd_eop),
        .rd_vld       (rd_vld),
        .rd_data      (rd_data),
        .ready        (ready),
        .pkt_done     (pkt_done),
        .pkt_err      (pkt_err),
        .pkt_dest     (pkt_dest),
        .pkt_priority (pkt_priority),
        .pkt_length   (pkt_length),
        .pkt_cnt      (pkt_cnt),
        .err_cnt      (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] hdr(input int d, input int p, input int l, input int c);
        logic [31:0] h;
        h        = '0;
        h[2:0]   = 3'(d);
        h[5:3]   = 3'(p);
        h[14:6]  = 9'(l);
        h[30:15] = 16'(c);
        return h;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one beat for one clock edge; returns 1 time unit after the edge.
    task automatic beat(input logic s, input logic e, input logic [31:0] d);
        rd_sop  = s;
        rd_eop  = e;
        rd_data = d;
        rd_vld  = 1'b1;
        tick();
        rd_vld  = 1'b0;
        rd_sop  = 1'b0;
        rd_eop  = 1'b0;
        rd_data = '0;
    endtask

    initial begin
        rst     = 1'b1;
        rx_en   = 1'b1;
        rd_sop  = 1'b0;
        rd_eop  = 1'b0;
        rd_vld  = 1'b0;
        rd_data = '0;

        // Reset state
        #12;
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_done", 32'(pkt_done), 32'd0);
        chk("rst_cnts", {pkt_cnt, err_cnt}, 32'd0);
        rst = 1'b0;
        tick();
        chk("idle_ready", 32'(ready), 32'd1);

        // Good packet: dest 2, pri 1, L=10, C=55
        beat(1'b1, 1'b0, hdr(2, 1, 10, 55));
        for (int i = 1; i <= 10; i++) beat(1'b0, (i == 10), 32'(i));
        chk("good_done", 32'(pkt_done), 32'd1);
        chk("good_err", 32'(pkt_err), 32'd0);
        chk("good_len", 32'(pkt_length), 32'd10);
        chk("good_pri", 32'(pkt_priority), 32'd1);
        chk("good_dest", 32'(pkt_dest), 32'd2);
        chk("good_cnt", 32'(pkt_cnt), 32'd1);
        chk("done_ready", 32'(ready), 32'd0);
        tick();
        chk("done_pulse", 32'(pkt_done), 32'd0);
        chk("hold_dest", 32'(pkt_dest), 32'd2);

        // Wrong dest and bad checksum
        beat(1'b1, 1'b0, hdr(3, 1, 10, 0));
        for (int i = 1; i <= 10; i++) beat(1'b0, (i == 10), 32'(i));
        chk("dc_done", 32'(pkt_done), 32'd1);
        chk("dc_err", 32'(pkt_err), 32'b0101);
        chk("dc_errcnt", 32'(err_cnt), 32'd1);
        chk("dc_pktcnt", 32'(pkt_cnt), 32'd1);
        tick();

        // Short packet: L=10, eop on 8th beat, C=36 (sum 1..8)
        beat(1'b1, 1'b0, hdr(2, 0, 10, 36));
        for (int i = 1; i <= 8; i++) beat(1'b0, (i == 8), 32'(i));
        chk("short_err", 32'(pkt_err), 32'b0010);
        chk("short_len", 32'(pkt_length), 32'd8);
        tick();

        // Header-only packet
        beat(1'b1, 1'b1, hdr(2, 0, 0, 0));
        chk("ho_done", 32'(pkt_done), 32'd1);
        chk("ho_err", 32'(pkt_err), 32'd0);
        chk("ho_cnt", 32'(pkt_cnt), 32'd2);
        tick();

        // Mid-packet sop after 4 beats, then a complete good packet (L=3, C=18)
        beat(1'b1, 1'b0, hdr(2, 1, 10, 55));
        for (int i = 1; i <= 4; i++) beat(1'b0, 1'b0, 32'(i));
        beat(1'b1, 1'b0, hdr(2, 3, 3, 18));
        chk("mid_done", 32'(pkt_done), 32'd1);
        chk("mid_err", 32'(pkt_err), 32'b1110);
        chk("mid_len", 32'(pkt_length), 32'd4);
        chk("mid_errcnt", 32'(err_cnt), 32'd3);
        for (int i = 5; i <= 7; i++) beat(1'b0, (i == 7), 32'(i));
        chk("mid2_done", 32'(pkt_done), 32'd1);
        chk("mid2_err", 32'(pkt_err), 32'd0);
        chk("mid2_len", 32'(pkt_length), 32'd3);
        chk("mid2_pri", 32'(pkt_priority), 32'd3);
        chk("mid2_cnt", 32'(pkt_cnt), 32'd3);
        tick();

        // Flow control: rx_en low ignores beats
        rx_en = 1'b0;
        #1;
        chk("rxen_ready", 32'(ready), 32'd0);
        beat(1'b1, 1'b1, hdr(2, 0, 0, 0));
        chk("rxen_nodone", 32'(pkt_done), 32'd0);
        tick();
        chk("rxen_nocnt", 32'(pkt_cnt), 32'd3);

        // rx_en dropped mid-packet: ready held to eop (L=3, C=6)
        rx_en = 1'b1;
        beat(1'b1, 1'b0, hdr(2, 2, 3, 6));
        rx_en = 1'b0;
        #1;
        chk("hold_ready", 32'(ready), 32'd1);
        for (int i = 1; i <= 3; i++) beat(1'b0, (i == 3), 32'(i));
        chk("hold_err", 32'(pkt_err), 32'd0);
        chk("hold_cnt", 32'(pkt_cnt), 32'd4);
        tick();
        chk("rxen_idle", 32'(ready), 32'd0);
        rx_en = 1'b1;

        // Stray beats with no sop
        beat(1'b0, 1'b0, 32'd9);
        beat(1'b0, 1'b1, 32'd9);
        chk("stray_done", 32'(pkt_done), 32'd1);
        chk("stray_b3", 32'(pkt_err[3]), 32'd1);
        chk("stray_errcnt", 32'(err_cnt), 32'd4);
        tick();

        // Reset mid-packet, then a clean packet (L=2, C=30)
        beat(1'b1, 1'b0, hdr(2, 1, 5, 0));
        beat(1'b0, 1'b0, 32'd1);
        beat(1'b0, 1'b0, 32'd2);
        rst = 1'b1;
        #1;
        chk("arst_cnts", {pkt_cnt, err_cnt}, 32'd0);
        chk("arst_out", {28'd0, pkt_err} | 32'(pkt_dest) | 32'(pkt_length) | 32'(pkt_priority), 32'd0);
        chk("arst_ready", 32'(ready), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_done", 32'(pkt_done), 32'd0);
        beat(1'b1, 1'b0, hdr(2, 5, 2, 30));
        beat(1'b0, 1'b0, 32'd10);
        beat(1'b0, 1'b1, 32'd20);
        chk("rst_pkt_done", 32'(pkt_done), 32'd1);
        chk("rst_pkt_err", 32'(pkt_err), 32'd0);
        chk("rst_pkt_cnt", 32'(pkt_cnt), 32'd1);
        chk("rst_pkt_pri", 32'(pkt_priority), 32'd5);
        chk("rst_pkt_len", 32'(pkt_length), 32'd2);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pkt_recv_module.md
# pkt_recv_module

Per-port packet receiver and checker for the shared-cache switch bench and for integration at each switch output port. It accepts the `rd_sop/rd_eop/rd_vld/rd_data` stream that the switch drives for one output port and drives that port's `ready`. It parses and checks each packet's header word against the payload that follows, then reports completion, decoded fields, error flags and running counts. It is the receiving end of the packet format that the sender generates into `wr_*`.

## Interface
- `DATA_WIDTH`, 32: width of one beat.
- `PORT_ID`, 0: output port index this receiver sits on.
- `WIDTH_SEL`, 3: destination field width, equal to $clog2(PORT_NUB_TOTAL).
- `WIDTH_PRIORITY`, 3: priority field width.
- `WIDTH_LENGTH`, 9: length field width, equal to $clog2(DATA_LENGTH_MAX).
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `rx_en`  in  1  permits acceptance of new packets.
- `rd_sop`  in  1  first beat of a packet; this beat is the header.
- `rd_eop`  in  1  last beat of a packet.
- `rd_vld`  in  1  beat valid.
- `rd_data`  in  DATA_WIDTH  beat data.
- `ready`  out  1  receiver accepts beats.
- `pkt_done`  out  1  one-cycle pulse: packet finished (good or bad).
- `pkt_err`  out  4  error flags, valid with `pkt_done`. Bit 0: destination mismatch. Bit 1: length mismatch. Bit 2: checksum mismatch. Bit 3: framing error.
- `pkt_dest`  out  WIDTH_SEL  header destination of the last packet.
- `pkt_priority`  out  WIDTH_PRIORITY  header priority of the last packet.
- `pkt_length`  out  WIDTH_LENGTH  payload beats actually received (saturating).
- `pkt_cnt`  out  16  count of packets finished with `pkt_err==0`; wraps.
- `err_cnt`  out  16  count of packets finished with `pkt_err!=0`; wraps.

## Operation
- A beat is accepted when `rd_vld && ready`. Beats with `ready` low are ignored.
- Header beat layout, with the LSB first:
  - `[WIDTH_SEL-1:0]` dest
  - next `WIDTH_PRIORITY` bits: priority
  - next `WIDTH_LENGTH` bits: L, the number of payload beats after the header
  - next 16 bits: C, the checksum
  - remaining bits: ignored
- C is the mod-2^16 sum of `rd_data[15:0]` over all payload beats.
- States:
  - IDLE → RECV when an accepted beat has `rd_sop` and not `rd_eop`. Header fields are latched; the beat counter and checksum accumulator are cleared.
  - IDLE → DONE when an accepted beat has `rd_sop && rd_eop` (header-only packet). The length check expects L==0.
  - IDLE, accepted beat without `rd_sop`: the beat is discarded. The block goes to DRAIN with bit 3 set, or to DONE if the beat carries `rd_eop`.
  - RECV, accepted beat without `rd_sop`: the counter increments, saturating at 2^WIDTH_LENGTH-1, and `rd_data[15:0]` is added into the accumulator. With `rd_eop` set, the block goes to DONE.
  - RECV, accepted beat with `rd_sop` (mid-packet sop): the current packet is reported with bit 3 set plus any other mismatches. The new beat is latched as a fresh header in the same cycle, and the state stays RECV (or goes to DONE if `rd_eop` is also set).
  - DRAIN: accepted beats are discarded until `rd_eop`, then DONE. A `rd_sop` seen in DRAIN restarts as in IDLE.
  - DONE: one cycle. Drives `pkt_done`, `pkt_err` and the counters, then returns to IDLE.
- Error checks at DONE:
  - bit 0: dest != PORT_ID
  - bit 1: received count != L
  - bit 2: accumulator != C
- `ready` is high in IDLE when `rx_en` is high. From an accepted sop through the eop beat, `ready` is held high regardless of `rx_en`. `ready` is low in DONE.

## Timing
- Reset sets every output to 0 and the state to IDLE. This takes effect immediately and asynchronously. Reset mid-packet discards the packet with no `pkt_done`.
- `pkt_done` asserts exactly 1 cycle after the accepted eop beat, for 1 cycle.
- `pkt_dest`, `pkt_priority` and `pkt_length` update in the DONE cycle and hold until the next DONE.
- A mid-packet sop generates its `pkt_done` the cycle after the offending beat. The new packet is unaffected.
- Back-to-back packets: a sop arriving in the DONE cycle is not accepted (`ready` low). The earliest next sop is accepted 2 cycles after the previous eop.
- `pkt_cnt` and `err_cnt` wrap from 0xFFFF to 0.

## Test plan
- Good packet, PORT_ID=2, `rx_en=1`: header dest=2, pri=1, L=10, C equal to the sum of 10 payload words 1..10 (=55), eop on the last word. Expect `pkt_done` 1 cycle after eop, `pkt_err=0`, `pkt_length=10`, `pkt_priority=1`, `pkt_cnt=1`.
- Wrong destination and bad checksum: dest=3, C=0 on the same payload. Expect `pkt_err=4'b0101`, `err_cnt=1`, `pkt_cnt` unchanged.
- Short packet: L=10 but eop on the 8th payload beat. Expect `pkt_err[1]=1` and `pkt_length=8`. Header-only sop+eop beat with L=0 and C=0: expect `pkt_err=0`.
- Mid-packet sop after 4 payload beats, then a complete valid packet. Expect a first `pkt_done` with bit 3 set, then a second `pkt_done` with `pkt_err=0`.
- Flow control: `rx_en=0` with `rd_vld` pulsed. Expect `ready=0` and no activity. Drop `rx_en` mid-packet: expect `ready` held high to eop. Stray beats with no sop: expect bit 3 set after their eop.
- Assert `rst` mid-packet, then send a good packet. Expect all outputs 0 during reset, no `pkt_done` for the aborted packet, and a clean report for the next packet.
